// File: rtl/beta_pkg.sv
// Shared types and constants for the IF/DEC skid pipeline register.
package beta_pkg;

  // Occupancy of the two-entry skid register
  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_t;

  // addi x0,x0,0 -- shown to decode whenever no entry is valid
  localparam logic [31:0] BETA_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/beta_if_dec_skid_pipe.sv
// Fetch-to-decode pipeline register, valid/ready handshake, 2-entry skid buffer.
// Optional feature macro: BETA_IFDEC_PERF_EN adds pip_stall_cnt_o, a saturating
// count of cycles in which decode holds a valid entry that is not consumed.
module beta_if_dec_skid_pipe
  import beta_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter logic [DataWidth-1:0] NopInstr  = DataWidth'(BETA_NOP_INSTR)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 pip_valid_i,
  output logic                 pip_ready_o,
  input  logic [DataWidth-1:0] pip_instr_i,
  input  logic [DataWidth-1:0] pip_next_pc_i,
  output logic                 pip_valid_o,
  input  logic                 pip_ready_i,
  output logic [DataWidth-1:0] pip_instr_o,
  output logic [DataWidth-1:0] pip_next_pc_o,
  input  logic                 pip_stall_i,
  input  logic                 pip_flush_i
`ifdef BETA_IFDEC_PERF_EN
  ,
  output logic [31:0]          pip_stall_cnt_o
`endif
);

  skid_state_t          state_q, state_d;
  logic [DataWidth-1:0] head_instr_q, head_pc_q;
  logic [DataWidth-1:0] skid_instr_q, skid_pc_q;
  logic                 push, pop;
  logic                 head_we, skid_we, head_from_skid;

  // Handshake flags are decoded from the state register only, so ready
  // never depends combinationally on pip_ready_i.
  assign pip_ready_o = (state_q != SKID_FULL);
  assign pip_valid_o = (state_q != SKID_EMPTY);
  assign push        = pip_valid_i & pip_ready_o;
  assign pop         = pip_valid_o & pip_ready_i & ~pip_stall_i;

  // Payload registers stay untouched on bubbles; the idle value is muxed in.
  assign pip_instr_o   = pip_valid_o ? head_instr_q : NopInstr;
  assign pip_next_pc_o = pip_valid_o ? head_pc_q    : '0;

  // Next-state and payload write enables; flush drops everything incl. this cycle's push
  always_comb begin
    state_d        = state_q;
    head_we        = 1'b0;
    skid_we        = 1'b0;
    head_from_skid = 1'b0;
    if (pip_flush_i) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            state_d = SKID_ONE;
            head_we = 1'b1;
          end
        end
        SKID_ONE: begin
          if (push && pop) begin
            head_we = 1'b1;
          end else if (push) begin
            state_d = SKID_FULL;
            skid_we = 1'b1;
          end else if (pop) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            state_d        = SKID_ONE;
            head_we        = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  // Occupancy register, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= SKID_EMPTY;
    else         state_q <= state_d;
  end

  // Head payload: loaded from fetch, or promoted from the skid slot on drain
  always_ff @(posedge clk_i) begin
    if (rstn_i && head_we) begin
      head_instr_q <= head_from_skid ? skid_instr_q : pip_instr_i;
      head_pc_q    <= head_from_skid ? skid_pc_q    : pip_next_pc_i;
    end
  end

  // Skid payload: catches the word accepted while decode is back-pressuring
  always_ff @(posedge clk_i) begin
    if (rstn_i && skid_we) begin
      skid_instr_q <= pip_instr_i;
      skid_pc_q    <= pip_next_pc_i;
    end
  end

`ifdef BETA_IFDEC_PERF_EN
  logic [31:0] stall_cnt_q;

  // Back-pressure counter: saturating, cleared only by reset (flush keeps it)
  always_ff @(posedge clk_i) begin
    if (!rstn_i)                                      stall_cnt_q <= '0;
    else if (pip_valid_o && !pop && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign pip_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_beta_if_dec_skid_pipe.sv
// Bench for beta_if_dec_skid_pipe: directed scenarios with literal expectations
// plus a queue-based reference model checked every cycle on the falling edge.
module tb_beta_if_dec_skid_pipe;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid_i, ready_i, stall_i, flush_i;
  logic [DW-1:0] instr_i, pc_i;
  logic          ready_o, valid_o;
  logic [DW-1:0] instr_o, pc_o;
`ifdef BETA_IFDEC_PERF_EN
  logic [31:0]   cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  beta_if_dec_skid_pipe #(.DataWidth(DW)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .pip_valid_i   (valid_i),
    .pip_ready_o   (ready_o),
    .pip_instr_i   (instr_i),
    .pip_next_pc_i (pc_i),
    .pip_valid_o   (valid_o),
    .pip_ready_i   (ready_i),
    .pip_instr_o   (instr_o),
    .pip_next_pc_o (pc_o),
    .pip_stall_i   (stall_i),
    .pip_flush_i   (flush_i)
`ifdef BETA_IFDEC_PERF_EN
    ,
    .pip_stall_cnt_o (cnt_o)
`endif
  );

  // ---------------- reference model: a FIFO of at most two words ----------
  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] pc;
  } word_t;

  word_t       mq[$];
  logic [31:0] mcnt = '0;
  bit          model_ok = 0;

  always @(posedge clk) begin
    bit    m_push, m_pop;
    word_t w;
    if (!rstn) begin
      mq.delete();
      mcnt     = '0;
      model_ok = 1;
    end else if (model_ok) begin
      m_push = valid_i && (mq.size() < 2);
      m_pop  = (mq.size() > 0) && ready_i && !stall_i;
      if (mq.size() > 0 && !m_pop && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
      if (flush_i) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          w.instr = instr_i;
          w.pc    = pc_i;
          mq.push_back(w);
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic          e_valid, e_ready;
    logic [DW-1:0] e_instr, e_pc;
    bit            bad;
    if (model_ok) begin
      e_valid = (mq.size() > 0);
      e_ready = (mq.size() < 2);
      e_instr = e_valid ? mq[0].instr : 32'h13;
      e_pc    = e_valid ? mq[0].pc    : '0;
      bad = (valid_o !== e_valid) || (ready_o !== e_ready) ||
            (instr_o !== e_instr) || (pc_o !== e_pc);
`ifdef BETA_IFDEC_PERF_EN
      if (cnt_o !== mcnt) bad = 1;
`endif
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL model t=%0t valid %b/%b ready %b/%b instr %h/%h pc %h/%h (got/exp)",
                 $time, valid_o, e_valid, ready_o, e_ready, instr_o, e_instr, pc_o, e_pc);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] ins, input logic r);
    valid_i = v;
    instr_i = ins;
    pc_i    = ins + 32'd4;
    ready_i = r;
  endtask

  initial begin
    rstn = 1'b0; valid_i = 0; ready_i = 0; stall_i = 0; flush_i = 0;
    instr_i = '0; pc_i = '0;

    // 1 reset
    step();
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_instr", instr_o, 32'h13);
    chk("rst_pc",    pc_o,    0);
    rstn = 1'b1;

    // 2 streaming: each word visible the cycle after acceptance, no gaps
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'hA + i, 1);
      step();
      chk("stream_valid", valid_o, 1);
      chk("stream_instr", instr_o, 32'hA + i);
      chk("stream_pc",    pc_o,    32'hE + i);
    end
    drive(0, 0, 1);
    step();
    chk("stream_drain", valid_o, 0);

    // 3 back-pressure into FULL, then drain in order
    drive(1, 32'h100, 0); step();
    drive(1, 32'h104, 0); step();
    chk("bp_ready_full", ready_o, 0);
    chk("bp_head",       instr_o, 32'h100);
    drive(0, 0, 1); step();
    chk("bp_first_out", instr_o, 32'h104);
    chk("bp_ready_back", ready_o, 1);
    step();
    chk("bp_empty", valid_o, 0);

    // 4 flush in FULL with a word offered at the same time
    drive(1, 32'h1, 0); step();
    drive(1, 32'h2, 0); step();
    drive(1, 32'h200, 0); flush_i = 1; step();
    flush_i = 0;
    chk("flush_valid", valid_o, 0);
    chk("flush_instr", instr_o, 32'h13);
    chk("flush_pc",    pc_o,    0);
    drive(0, 0, 1); step();
    chk("flush_no_200", valid_o, 0);

    // 5 stall holds the head; counter starts from a fresh reset
    rstn = 0; step(); rstn = 1;
    drive(1, 32'h300, 1); step();
    drive(0, 0, 1); stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", instr_o, 32'h300);
    end
`ifdef BETA_IFDEC_PERF_EN
    chk("stall_cnt3", cnt_o, 3);
`endif
    stall_i = 0; step();
    chk("stall_release", valid_o, 0);
`ifdef BETA_IFDEC_PERF_EN
    chk("stall_cnt_hold", cnt_o, 3);
`endif

    // 6 reset while FULL
    drive(1, 32'h400, 0); step();
    drive(1, 32'h404, 0); step();
    chk("mid_full", ready_o, 0);
    rstn = 0; step(); rstn = 1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_ready", ready_o, 1);

    // random valid/ready/stall/flush run checked by the model
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6);
      pc_i    = $urandom;
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 49) == 0);
      rstn    = ($urandom_range(0, 999) != 0);
      step();
    end
    rstn = 1; drive(0, 0, 1); stall_i = 0; flush_i = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
